sar_adc_ctrl: RTL and testbench

Successive-approximation conversion controller that produces the 10-bit digital samples consumed by the ADC-to-DAC signal path. It drives a trial code into an external comparator DAC and steers the analog track/hold switch. It reads a 1-bit comparator decision and resolves one bit per step, MSB first. A start/busy/valid handshake frames each conversion, and the finished code is held on `data_out` for the downstream stage.

---
 rtl/sar_adc_ctrl.sv | 142 ++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation conversion controller: steers track/hold, drives
// trial codes to the comparator DAC and resolves one bit per step, MSB first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, sample switch open, last result held
// ACQUIRE | track phase, sample switch closed for ACQ_CYCLES cycles
// SETTLE  | trial code on the DAC, waiting SETTLE_CYCLES for it to settle
// DECIDE  | comparator sampled at the closing edge, one bit resolved
// DONE    | one-cycle data_valid; start here chains the next conversion
module sar_adc_ctrl #(
  parameter int WIDTH         = 10,
  parameter int ACQ_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             comp_in,
  output logic             sample_hold,
  output logic [WIDTH-1:0] dac_trial,
  output logic             busy,
  output logic             data_valid,
  output logic [WIDTH-1:0] data_out
);

  localparam int CNT_MAX = (ACQ_CYCLES > SETTLE_CYCLES) ? ACQ_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ACQ_LOAD    = CNT_W'(ACQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACQUIRE = 3'd1,
    SETTLE  = 3'd2,
    DECIDE  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] next_mask;
  logic [WIDTH-1:0] result_next;

  // result only ever holds decided bits; the trial bit is added on the DAC side
  assign bit_mask    = ONE << bit_idx;
  assign next_mask   = ONE << (bit_idx - IDX_ONE);
  assign result_next = comp_in ? (result | bit_mask) : result;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      result      <= '0;
      sample_hold <= 1'b0;
      dac_trial   <= '0;
      busy        <= 1'b0;
      data_valid  <= 1'b0;
      data_out    <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= ACQUIRE;
            busy        <= 1'b1;
            sample_hold <= 1'b1;
            cnt         <= ACQ_LOAD;
          end
        end

        ACQUIRE: begin
          if (cnt == '0) begin
            sample_hold <= 1'b0;
            result      <= '0;
            bit_idx     <= MSB_IDX;
            dac_trial   <= ONE << MSB_IDX;
            cnt         <= SETTLE_LOAD;
            state       <= (SETTLE_CYCLES == 0) ? DECIDE : SETTLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        SETTLE: begin
          if (cnt == '0) begin
            state <= DECIDE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        DECIDE: begin
          result <= result_next;
          if (bit_idx == '0) begin
            data_out   <= result_next;
            data_valid <= 1'b1;
            busy       <= 1'b0;
            dac_trial  <= '0;
            state      <= DONE;
          end else begin
            bit_idx   <= bit_idx - IDX_ONE;
            dac_trial <= result_next | next_mask;
            cnt       <= SETTLE_LOAD;
            state     <= (SETTLE_CYCLES == 0) ? DECIDE : SETTLE;
          end
        end

        DONE: begin
          if (start) begin
            state       <= ACQUIRE;
            busy        <= 1'b1;
            sample_hold <= 1'b1;
            cnt         <= ACQ_LOAD;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Completion and busy are mutually exclusive; tracking only happens inside a conversion.
  a_valid_not_busy: assert property (@(posedge clk) disable iff (rst) !(busy && data_valid));
  a_track_in_busy:  assert property (@(posedge clk) disable iff (rst) (!sample_hold || busy));
`endif

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: ideal comparator, timeline model of the
// conversion checked every cycle, plus directed literal checks.
module tb_sar_adc_ctrl;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         comp_in;
  logic         sample_hold;
  logic [W-1:0] dac_trial;
  logic         busy;
  logic         data_valid;
  logic [W-1:0] data_out;
  logic [W-1:0] vin;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  bit cmp_en     = 1'b0;

  sar_adc_ctrl #(.WIDTH(W), .ACQ_CYCLES(4), .SETTLE_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .comp_in     (comp_in),
    .sample_hold (sample_hold),
    .dac_trial   (dac_trial),
    .busy        (busy),
    .data_valid  (data_valid),
    .data_out    (data_out)
  );

  always #5 clk = ~clk;

  assign comp_in = (vin >= dac_trial);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ideal SAR resolves vin exactly, so step s trial = top s bits of vin plus the next bit.
  function automatic logic [W-1:0] model_trial(input logic [W-1:0] v, input int s);
    logic [W-1:0] top_mask;
    top_mask = ~((10'd1 << (W - s)) - 10'd1);
    return (v & top_mask) | (10'd1 << (W - 1 - s));
  endfunction

  // Timeline model: k = cycles since the accepting start edge, -1 when idle.
  int           m_k = -1;
  logic [W-1:0] m_vin = '0;
  logic [W-1:0] m_dout = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_k    <= -1;
      m_dout <= '0;
    end else if ((m_k == -1 || m_k == 34) && start) begin
      m_k   <= 0;
      m_vin <= vin;
    end else if (m_k >= 0 && m_k < 33) begin
      m_k <= m_k + 1;
    end else if (m_k == 33) begin
      m_k    <= 34;
      m_dout <= m_vin;
    end else if (m_k == 34) begin
      m_k <= -1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_k >= 0 && m_k <= 33)});
      chk("sample_hold", {31'd0, sample_hold}, {31'd0, (m_k >= 0 && m_k <= 3)});
      chk("data_valid", {31'd0, data_valid}, {31'd0, (m_k == 34)});
      chk("data_out", {22'd0, data_out}, {22'd0, m_dout});
      chk("dac_trial", {22'd0, dac_trial},
          (m_k >= 4 && m_k <= 33) ? {22'd0, model_trial(m_vin, (m_k - 4) / 3)} : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [W-1:0] cap_trial [W];

  task automatic do_conv(input logic [W-1:0] v, output int lat, output logic [W-1:0] dout);
    vin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = -1;
    dout  = '0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n >= 4 && n <= 33 && ((n - 4) % 3) == 0) cap_trial[(n - 4) / 3] = dac_trial;
      if (data_valid) begin
        lat  = n;
        dout = data_out;
        break;
      end
    end
  endtask

  int           lat;
  logic [W-1:0] dout;
  int           dv_times [3];
  logic [W-1:0] dv_data  [3];
  int           n_dv;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    vin   = '0;
    tick();
    cmp_en = 1'b1;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sample_hold", {31'd0, sample_hold}, 32'd0);
    chk("rst_dac_trial", {22'd0, dac_trial}, 32'd0);
    chk("rst_data_out", {22'd0, data_out}, 32'd0);
    chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
    rst = 1'b0;
    tick();

    do_conv(10'h2AB, lat, dout);
    chk("lat_2ab", lat, 34);
    chk("dout_2ab", {22'd0, dout}, 32'h2AB);
    repeat (3) tick();

    do_conv(10'h200, lat, dout);
    chk("trial0_200", {22'd0, cap_trial[0]}, 32'h200);
    chk("trial1_200", {22'd0, cap_trial[1]}, 32'h300);
    chk("trial2_200", {22'd0, cap_trial[2]}, 32'h280);
    chk("trial3_200", {22'd0, cap_trial[3]}, 32'h240);
    chk("trial9_200", {22'd0, cap_trial[9]}, 32'h201);
    chk("dout_200", {22'd0, dout}, 32'h200);
    repeat (2) tick();

    do_conv(10'h000, lat, dout);
    chk("dout_000", {22'd0, dout}, 32'h000);
    do_conv(10'h3FF, lat, dout);
    chk("dout_3ff", {22'd0, dout}, 32'h3FF);
    chk("trial9_3ff", {22'd0, cap_trial[9]}, 32'h3FF);
    repeat (2) tick();

    // start held high: back-to-back conversions, no restart while busy
    vin   = 10'h155;
    start = 1'b1;
    n_dv  = 0;
    for (int n = 0; n < 200 && n_dv < 3; n++) begin
      tick();
      if (data_valid) begin
        dv_times[n_dv] = n;
        dv_data[n_dv]  = data_out;
        n_dv++;
      end
    end
    start = 1'b0;
    chk("cont_count", n_dv, 3);
    if (n_dv == 3) begin
      chk("cont_period1", dv_times[1] - dv_times[0], 35);
      chk("cont_period2", dv_times[2] - dv_times[1], 35);
      for (int i = 0; i < 3; i++) chk("cont_dout", {22'd0, dv_data[i]}, 32'h155);
    end
    repeat (40) tick();

    // reset in the middle of a conversion
    vin   = 10'h2AB;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_sample_hold", {31'd0, sample_hold}, 32'd0);
    chk("mid_rst_dac_trial", {22'd0, dac_trial}, 32'd0);
    chk("mid_rst_data_out", {22'd0, data_out}, 32'd0);
    chk("mid_rst_data_valid", {31'd0, data_valid}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    do_conv(10'h0F0, lat, dout);
    chk("lat_0f0", lat, 34);
    chk("dout_0f0", {22'd0, dout}, 32'h0F0);
    repeat (3) tick();

    // vin change without start leaves the held result alone
    do_conv(10'h100, lat, dout);
    chk("dout_100", {22'd0, dout}, 32'h100);
    tick();
    vin = 10'h300;
    repeat (20) tick();
    chk("hold_data_out", {22'd0, data_out}, 32'h100);
    chk("hold_data_valid", {31'd0, data_valid}, 32'd0);
    chk("hold_busy", {31'd0, busy}, 32'd0);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
